// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: op_type encodings,
// FSM state encodings and the register-address width.
package wb_sequencer_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned EXEC_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_DONE
  } state_t;

  function automatic logic is_mem_op(input op_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/wb_seq_counter.sv
// Loadable down-counter with a zero flag. Load wins over decrement and the
// count saturates at zero.
module wb_seq_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: load, else decrement toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wb_sequencer.sv
// Instruction sequencer: IDLE -> EXEC -> (MEM) -> (WB) -> DONE.
// All outputs are registered and derived from the next state.
// Optional feature macro: WB_SEQ_TIMEOUT_EN enables the memory-wait
// watchdog (MEM_TIMEOUT cycles) and the sticky err flag.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int unsigned ALU_LAT     = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op_type,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              ld_reg_ALU,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ld_reg_mem,
  output logic              sel_dat,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                accept;
  logic                exec_zero;
  logic [EXEC_CNT_W-1:0] exec_count;
  logic                tmo_expire;

  logic                busy_d, ld_alu_d, mem_req_d, mem_we_d, ld_mem_d;
  logic                sel_d, rf_we_d, done_d;
  logic [REG_AW-1:0]   waddr_d;

  assign accept = (state_q == ST_IDLE) && start;

  wb_seq_counter #(.W(EXEC_CNT_W)) u_exec_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (EXEC_CNT_W'(ALU_LAT - 1)),
    .dec      (state_q == ST_EXEC),
    .count    (exec_count),
    .zero     (exec_zero)
  );

`ifdef WB_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT) + 1;

  logic             mem_enter;
  logic             tmo_zero;
  logic [TMO_W-1:0] tmo_cnt_unused;

  assign mem_enter = (state_q == ST_EXEC) && exec_zero && is_mem_op(op_q);

  wb_seq_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mem_enter),
    .load_val (TMO_W'(MEM_TIMEOUT - 1)),
    .dec      (state_q == ST_MEM),
    .count    (tmo_cnt_unused),
    .zero     (tmo_zero)
  );

  // mem_ready in the expiry cycle takes priority, so no timeout then.
  assign tmo_expire = (state_q == ST_MEM) && !mem_ready && tmo_zero;

  // Sticky timeout flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (tmo_expire) begin
      err <= 1'b1;
    end
  end
`else
  localparam int unsigned MEM_TIMEOUT_UNUSED = MEM_TIMEOUT;

  assign tmo_expire = 1'b0;
  assign err        = 1'b0;
`endif

  // Next-state and captured-instruction logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_t'(op_type);
          rd_d    = rd_addr;
          state_d = (op_t'(op_type) == OP_NOP) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_zero) begin
          state_d = is_mem_op(op_q) ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (op_q == OP_LOAD) ? ST_WB : ST_DONE;
        end else if (tmo_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, computed from the next state.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    // Last EXEC cycle is next: either a one-cycle EXEC just starting, or one
    // count remaining in the current EXEC.
    ld_alu_d  = (accept && (op_t'(op_type) != OP_NOP) && (ALU_LAT == 1)) ||
                ((state_q == ST_EXEC) && (exec_count == EXEC_CNT_W'(1)));
    mem_req_d = (state_d == ST_MEM);
    mem_we_d  = (state_d == ST_MEM) && (op_q == OP_STORE);
    ld_mem_d  = (state_q == ST_MEM) && mem_ready && (op_q == OP_LOAD);
    sel_d     = sel_dat;
    rf_we_d   = 1'b0;
    waddr_d   = '0;
    if (state_d == ST_WB) begin
      sel_d   = (op_q == OP_LOAD);
      rf_we_d = (rd_q != '0);
      waddr_d = rd_q;
    end
    done_d    = (state_d == ST_DONE);
  end

  // State and captured-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ALU;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      ld_reg_ALU <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      ld_reg_mem <= 1'b0;
      sel_dat    <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      done       <= 1'b0;
    end else begin
      busy       <= busy_d;
      ld_reg_ALU <= ld_alu_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      ld_reg_mem <= ld_mem_d;
      sel_dat    <= sel_d;
      rf_we      <= rf_we_d;
      rf_waddr   <= waddr_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: the stimulus process pushes the
// expected per-instruction trace; a monitor rebuilds the observed trace
// from the outputs and compares when done pulses.
module tb_wb_sequencer;

  localparam int ALU_LAT = 2;
  localparam int MEM_TO  = 4;
`ifdef WB_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [1:0] T_ALU = 2'b00, T_LOAD = 2'b01, T_STORE = 2'b10, T_NOP = 2'b11;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ready = 1'b0;
  logic [1:0] op_type = 2'b00;
  logic [4:0] rd_addr = 5'd0;
  logic       busy, ld_reg_ALU, mem_req, mem_we, ld_reg_mem, sel_dat, rf_we, done, err;
  logic [4:0] rf_waddr;

  wb_sequencer #(.ALU_LAT(ALU_LAT), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_type(op_type), .rd_addr(rd_addr),
    .mem_ready(mem_ready), .busy(busy), .ld_reg_ALU(ld_reg_ALU), .mem_req(mem_req),
    .mem_we(mem_we), .ld_reg_mem(ld_reg_mem), .sel_dat(sel_dat), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int accept; int done_c; int alu_cnt; int alu_c; int mreq_cnt; int mwe_cnt;
    int ldm_cnt; int ldm_c; int rf_cnt; int rf_c; int waddr; int sel; int err_done;
  } rec_t;

  rec_t expq[$];
  int   passed = 0, total = 0;
  int   mem_n = 1, mem_k = 0;
  bit   model_sel = 1'b0, model_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reactive memory: ready on the mem_n-th request cycle, noise otherwise.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_k++;
      mem_ready = (mem_k == mem_n);
    end else begin
      mem_k = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: one trace per busy period, compared when done pulses.
  rec_t obs, mexp;
  bit   active = 1'b0;
  int   k = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (busy && !active) begin
        obs = '{default: 0};
        obs.accept = cyc;
        active = 1'b1;
        k = 0;
      end
      if (active) begin
        k++;
        if (k == 1) chk("err_cleared_on_start", err, 0);
        if (ld_reg_ALU) begin obs.alu_cnt++; obs.alu_c = k; end
        if (mem_req) obs.mreq_cnt++;
        if (mem_we) obs.mwe_cnt++;
        if (ld_reg_mem) begin obs.ldm_cnt++; obs.ldm_c = k; end
        if (rf_we) begin obs.rf_cnt++; obs.rf_c = k; obs.waddr = rf_waddr; end
        if (done) begin
          obs.done_c = k; obs.sel = sel_dat; obs.err_done = err;
          active = 1'b0;
          if (expq.size() == 0) begin
            total++;
            $display("FAIL unexpected_instr: got a completed instruction at cycle %0d, expected none", cyc);
          end else begin
            mexp = expq.pop_front();
            chk("accept_cycle", obs.accept, mexp.accept);
            chk("done_cycle", obs.done_c, mexp.done_c);
            chk("ld_alu_count", obs.alu_cnt, mexp.alu_cnt);
            chk("ld_alu_cycle", obs.alu_c, mexp.alu_c);
            chk("mem_req_cycles", obs.mreq_cnt, mexp.mreq_cnt);
            chk("mem_we_cycles", obs.mwe_cnt, mexp.mwe_cnt);
            chk("ld_mem_count", obs.ldm_cnt, mexp.ldm_cnt);
            chk("ld_mem_cycle", obs.ldm_c, mexp.ldm_c);
            chk("rf_we_count", obs.rf_cnt, mexp.rf_cnt);
            chk("rf_we_cycle", obs.rf_c, mexp.rf_c);
            chk("rf_waddr", obs.waddr, mexp.waddr);
            chk("sel_dat", obs.sel, mexp.sel);
            chk("err_at_done", obs.err_done, mexp.err_done);
          end
        end else if (!busy) begin
          chk("busy_until_done", busy, 1);
          active = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    model_sel = 1'b0;
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge in an IDLE cycle; drives the start for this cycle.
  task automatic issue(input logic [1:0] op, input logic [4:0] rd, input int n);
    rec_t e;
    bit   tmo, got;
    int   mc, wb;
    e = '{default: 0};
    tmo = 1'b0;
    wb = 0;
    e.accept = cyc + 1;
    case (op)
      T_NOP: e.done_c = 1;
      T_ALU: begin
        e.alu_cnt = 1; e.alu_c = ALU_LAT;
        wb = ALU_LAT + 1; e.done_c = ALU_LAT + 2;
      end
      default: begin
        tmo = TMO_EN && (n > MEM_TO);
        mc  = tmo ? MEM_TO : n;
        e.alu_cnt = 1; e.alu_c = ALU_LAT;
        e.mreq_cnt = mc;
        e.mwe_cnt = (op == T_STORE) ? mc : 0;
        if (op == T_LOAD && !tmo) begin
          e.ldm_cnt = 1; e.ldm_c = ALU_LAT + mc + 1;
          wb = ALU_LAT + mc + 1; e.done_c = wb + 1;
        end else begin
          e.done_c = ALU_LAT + mc + 1;
        end
      end
    endcase
    if (wb != 0) begin
      model_sel = (op == T_LOAD);
      if (rd != 5'd0) begin e.rf_cnt = 1; e.rf_c = wb; e.waddr = int'(rd); end
    end
    e.sel = model_sel;
    e.err_done = tmo;
    model_err = tmo;
    expq.push_back(e);

    mem_n = n;
    start = 1'b1; op_type = op; rd_addr = rd;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      // Noise while busy (and on the done cycle): must all be ignored.
      start = 1'($urandom_range(0, 1));
      op_type = 2'($urandom);
      rd_addr = 5'($urandom);
    end
    if (!got) begin
      total++;
      $display("FAIL done_timeout: got no done within 400 cycles, expected done at cycle %0d", e.done_c);
      expq.delete();
      do_reset();
      return;
    end
    @(negedge clk);
    start = 1'b0;
    chk("err_sticky_idle", err, model_err);
  endtask

  task automatic reset_mid_mem();
    mem_n = 1000;
    start = 1'b1; op_type = T_LOAD; rd_addr = 5'd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
    chk("mem_req_reached", mem_req, 1);
    chk("sel_hold_before_rst", sel_dat, model_sel);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_sel = 1'b0;
    model_err = 1'b0;
    #1;
    chk("rst_mem_req_drop", mem_req, 0);
    chk("rst_busy_drop", busy, 0);
    chk("rst_all_outputs",
        {busy, ld_reg_ALU, mem_req, mem_we, ld_reg_mem, sel_dat, rf_we, rf_waddr, done, err}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, ld_reg_ALU, mem_req, mem_we, ld_reg_mem, sel_dat, rf_we, rf_waddr, done, err}, 0);
    // Start driven together with reset release: accepted on the first edge.
    rst_n = 1'b1;
    issue(T_ALU, 5'd5, 1);
    issue(T_STORE, 5'd12, 1);
    issue(T_ALU, 5'd0, 1);
    issue(T_NOP, 5'd3, 1);
    issue(T_LOAD, 5'd9, 3);
    issue(T_LOAD, 5'd17, MEM_TO);
    reset_mid_mem();
    issue(T_LOAD, 5'd0, 2);
`ifdef WB_SEQ_TIMEOUT_EN
    issue(T_LOAD, 5'd7, 1000);
    repeat (2) @(negedge clk);
    issue(T_ALU, 5'd4, 1);
`endif
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2'($urandom), 5'($urandom), int'($urandom_range(1, 6)));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
